// File: rtl/rriot_pkg.sv
// Shared types and constants for the RRIOT bus master.
// Holds the FSM state enum, request bundle, FIFO sizing and error read value.
package rriot_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 8;
  localparam int PTR_W      = 2;
  localparam int LVL_W      = 3;

  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_EMPTY = '0;

  localparam logic [DATA_W-1:0] ERR_RDATA = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic              rs0;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // A read with OE low saw a floating bus; report the fixed error value.
  function automatic logic [DATA_W-1:0] read_result(
    input logic              oe,
    input logic [DATA_W-1:0] d
  );
    return oe ? d : ERR_RDATA;
  endfunction

endpackage

// File: rtl/rriot_req_fifo.sv
// 4-entry in-order request FIFO for the RRIOT bus master.
// Ports: clk/rst, push + push_data, pop, head (oldest entry), level, full.
module rriot_req_fifo
  import rriot_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  req_t             push_data,
  input  logic             pop,
  output req_t             head,
  output logic [LVL_W-1:0] level,
  output logic             full
);

  req_t             mem_q [FIFO_DEPTH];
  req_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (level_q == LVL_FULL);
  assign level = level_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    // Guard here too so a full FIFO can never be overwritten.
    do_push  = push && !full;
    do_pop   = pop && (level_q != LVL_EMPTY);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/rriot_bus_master.sv
// Queues requests and runs them as ADDR/DATA cycles on an RRIOT bus.
// Ports: req_* in (valid/ready), rsp_* out (valid/ready), bus_* to RRIOT, fifo_level, busy.
module rriot_bus_master
  import rriot_pkg::*;
(
  input  logic        phi2,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [9:0]  req_addr,
  input  logic        req_rs0,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_we,
  output logic        rsp_err,
  output logic [9:0]  bus_addr,
  output logic        bus_rs0,
  output logic        bus_we_n,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_oe,
  output logic [2:0]  fifo_level,
  output logic        busy
);

  state_e           state_q;
  state_e           state_d;
  req_t             txn_q;
  req_t             txn_d;
  req_t             in_req;
  req_t             head;
  logic [7:0]       rdata_q;
  logic [7:0]       rdata_d;
  logic             err_q;
  logic             err_d;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             fifo_empty;
  logic             is_idle;
  logic             accept;
  logic             take;
  logic             fifo_push;
  logic             fifo_pop;

  assign in_req = '{
    we:    req_we,
    addr:  req_addr,
    rs0:   req_rs0,
    wdata: req_wdata
  };

  assign fifo_empty = (level == LVL_EMPTY);
  assign is_idle    = (state_q == ST_IDLE);

  rriot_req_fifo u_fifo (
    .clk       (phi2),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (in_req),
    .pop       (fifo_pop),
    .head      (head),
    .level     (level),
    .full      (full)
  );

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (take)      state_d = ST_ADDR;
      ST_ADDR:                state_d = ST_DATA;
      ST_DATA:                state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // An accept into an empty FIFO while idle falls straight through to
  // the transaction register, so ADDR follows the accept by one cycle.
  always_comb begin
    req_ready = !full;
    accept    = req_valid && req_ready;
    take      = is_idle && (!fifo_empty || accept);
    fifo_pop  = is_idle && !fifo_empty;
    fifo_push = accept && !(is_idle && fifo_empty);
    bus_we_n  = !((state_q == ST_DATA) && txn_q.we);
    rsp_valid = (state_q == ST_RESP);
    busy      = !is_idle || !fifo_empty;
  end

  always_comb begin
    txn_d   = txn_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (take) begin
      txn_d = fifo_empty ? in_req : head;
    end
    if (state_q == ST_DATA) begin
      if (txn_q.we) begin
        rdata_d = '0;
        err_d   = 1'b0;
      end else begin
        rdata_d = read_result(bus_oe, bus_rdata);
        err_d   = !bus_oe;
      end
    end
  end

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      txn_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      txn_q   <= txn_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The transaction register only changes on a take, so the bus lines
  // hold their last values outside ADDR/DATA.
  assign bus_addr   = txn_q.addr;
  assign bus_rs0    = txn_q.rs0;
  assign bus_wdata  = txn_q.wdata;
  assign rsp_rdata  = rdata_q;
  assign rsp_we     = txn_q.we;
  assign rsp_err    = err_q;
  assign fifo_level = level;

endmodule

// File: tb/tb_rriot_bus_master.sv
// Directed self-checking bench for rriot_bus_master.
// Drives #1 after phi2 rises and samples there; a bus model supplies read data.
module tb_rriot_bus_master;

  logic       phi2;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [9:0] req_addr;
  logic       req_rs0;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_we;
  logic       rsp_err;
  logic [9:0] bus_addr;
  logic       bus_rs0;
  logic       bus_we_n;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_oe;
  logic [2:0] fifo_level;
  logic       busy;

  logic       use_model;
  logic [7:0] rdata_fix;
  logic [7:0] exp_q [$];
  int         n_checks;
  int         n_errors;

  rriot_bus_master dut (
    .phi2       (phi2),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_rs0    (req_rs0),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_we     (rsp_we),
    .rsp_err    (rsp_err),
    .bus_addr   (bus_addr),
    .bus_rs0    (bus_rs0),
    .bus_we_n   (bus_we_n),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_oe     (bus_oe),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  // Read data is a function of the address so ordering is visible.
  always_comb begin
    bus_rdata = use_model ? (bus_addr[7:0] ^ 8'h3C) : rdata_fix;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge phi2);
    #1;
  endtask

  task automatic send(input logic we, input logic [9:0] a,
                      input logic rs0, input logic [7:0] wd);
    chk("req_ready_on_send", 32'(req_ready), 32'h1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_rs0   = rs0;
    req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    int got;
    int budget;
    got    = 0;
    budget = 0;
    rsp_ready = 1'b1;
    while (got < n && budget < 100) begin
      if (rsp_valid) begin
        chk("drain_rdata", 32'(rsp_rdata), 32'(exp_q.pop_front()));
        got++;
      end
      step();
      budget++;
    end
    chk("drain_count", 32'(got), 32'(n));
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_rs0   = 1'b0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    bus_oe    = 1'b1;
    use_model = 1'b0;
    rdata_fix = 8'h00;

    #2;
    chk("rst_we_n", 32'(bus_we_n), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_addr", 32'(bus_addr), 32'h0);
    chk("rst_rdata", 32'(rsp_rdata), 32'h0);
    step();
    step();
    rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'h1);

    // Write: bus_we_n low only at N+2.
    send(1'b1, 10'h380, 1'b0, 8'h5A);
    chk("wr_n1_we_n", 32'(bus_we_n), 32'h1);
    chk("wr_n1_addr", 32'(bus_addr), 32'h380);
    chk("wr_n1_busy", 32'(busy), 32'h1);
    step();
    chk("wr_n2_we_n", 32'(bus_we_n), 32'h0);
    chk("wr_n2_addr", 32'(bus_addr), 32'h380);
    chk("wr_n2_wdata", 32'(bus_wdata), 32'h5A);
    chk("wr_n2_rs0", 32'(bus_rs0), 32'h0);
    step();
    chk("wr_n3_we_n", 32'(bus_we_n), 32'h1);
    chk("wr_n3_valid", 32'(rsp_valid), 32'h1);
    chk("wr_n3_rsp_we", 32'(rsp_we), 32'h1);
    chk("wr_n3_rdata", 32'(rsp_rdata), 32'h00);
    chk("wr_n3_err", 32'(rsp_err), 32'h0);
    step();
    chk("wr_n4_valid", 32'(rsp_valid), 32'h0);
    chk("wr_n4_busy", 32'(busy), 32'h0);
    chk("wr_n4_hold_addr", 32'(bus_addr), 32'h380);

    // Read with OE high.
    rdata_fix = 8'hA5;
    bus_oe    = 1'b1;
    send(1'b0, 10'h380, 1'b1, 8'h00);
    chk("rd_n1_rs0", 32'(bus_rs0), 32'h1);
    step();
    chk("rd_n2_we_n", 32'(bus_we_n), 32'h1);
    step();
    chk("rd_n3_valid", 32'(rsp_valid), 32'h1);
    chk("rd_n3_rdata", 32'(rsp_rdata), 32'hA5);
    chk("rd_n3_err", 32'(rsp_err), 32'h0);
    chk("rd_n3_rsp_we", 32'(rsp_we), 32'h0);
    step();

    // Read with OE low.
    rdata_fix = 8'h77;
    bus_oe    = 1'b0;
    send(1'b0, 10'h123, 1'b0, 8'h00);
    step();
    step();
    chk("oe0_valid", 32'(rsp_valid), 32'h1);
    chk("oe0_rdata", 32'(rsp_rdata), 32'hFF);
    chk("oe0_err", 32'(rsp_err), 32'h1);
    step();
    bus_oe = 1'b1;

    // Five back-to-back reads with the consumer stalled.
    use_model = 1'b1;
    rsp_ready = 1'b0;
    send(1'b0, 10'h101, 1'b0, 8'h00);
    send(1'b0, 10'h102, 1'b0, 8'h00);
    send(1'b0, 10'h103, 1'b0, 8'h00);
    send(1'b0, 10'h104, 1'b0, 8'h00);
    send(1'b0, 10'h105, 1'b0, 8'h00);
    chk("bp_level4", 32'(fifo_level), 32'h4);
    chk("bp_ready0", 32'(req_ready), 32'h0);
    req_valid = 1'b1;
    req_addr  = 10'h1FF;
    step();
    step();
    req_valid = 1'b0;
    chk("bp_level_held", 32'(fifo_level), 32'h4);
    chk("bp_stall_valid", 32'(rsp_valid), 32'h1);
    exp_q.push_back(8'h3D);
    exp_q.push_back(8'h3E);
    exp_q.push_back(8'h3F);
    exp_q.push_back(8'h38);
    exp_q.push_back(8'h39);
    drain(5);
    step();
    chk("bp_idle_after", 32'(busy), 32'h0);

    // Push and pop together at level 2, then wrap the pointers.
    send(1'b0, 10'h210, 1'b0, 8'h00);
    send(1'b0, 10'h211, 1'b0, 8'h00);
    send(1'b0, 10'h212, 1'b0, 8'h00);
    chk("pp_resp_a", 32'(rsp_valid), 32'h1);
    chk("pp_rdata_a", 32'(rsp_rdata), 32'h2C);
    chk("pp_level2", 32'(fifo_level), 32'h2);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("pp_idle_level", 32'(fifo_level), 32'h2);
    send(1'b0, 10'h213, 1'b0, 8'h00);
    chk("pp_level_same", 32'(fifo_level), 32'h2);
    chk("pp_busy", 32'(busy), 32'h1);
    send(1'b0, 10'h214, 1'b0, 8'h00);
    send(1'b0, 10'h215, 1'b0, 8'h00);
    chk("pp_level4", 32'(fifo_level), 32'h4);
    exp_q.push_back(8'h2D);
    exp_q.push_back(8'h2E);
    exp_q.push_back(8'h2F);
    exp_q.push_back(8'h28);
    exp_q.push_back(8'h29);
    drain(5);
    step();
    chk("pp_idle_after", 32'(busy), 32'h0);

    // Reset in the middle of a write DATA cycle.
    use_model = 1'b0;
    rsp_ready = 1'b1;
    send(1'b1, 10'h055, 1'b1, 8'hC3);
    send(1'b1, 10'h056, 1'b0, 8'h3C);
    chk("mr_data_we_n", 32'(bus_we_n), 32'h0);
    chk("mr_level1", 32'(fifo_level), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_we_n", 32'(bus_we_n), 32'h1);
    chk("mr_valid", 32'(rsp_valid), 32'h0);
    chk("mr_level", 32'(fifo_level), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_addr", 32'(bus_addr), 32'h0);
    step();
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen++;
      step();
    end
    chk("mr_no_rsp", 32'(seen), 32'h0);
    chk("mr_busy_after", 32'(busy), 32'h0);
    chk("mr_we_n_after", 32'(bus_we_n), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
